// File: rtl/wam_pkg.sv
// Shared types for the whack-a-mole round controller: FSM state encoding, difficulty codes,
// BCD score width and the difficulty-cycling helper.
package wam_pkg;

  localparam int BCD_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_PLAY   = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

  function automatic logic [1:0] diff_next(input logic [1:0] d);
    case (d)
      DIFF_EASY: return DIFF_MED;
      DIFF_MED:  return DIFF_HARD;
      default:   return DIFF_EASY;
    endcase
  endfunction

endpackage

// File: rtl/wam_debounce.sv
// Button conditioner: 2-flop synchroniser, level flips after DEB_CYC consecutive differing cycles,
// one-cycle rise pulse the cycle after the debounced level goes high. No backpressure.
module wam_debounce #(
  parameter int DEB_CYC = 500_000
) (
  input  logic clk,
  input  logic clr,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with the output restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) level_d = sync2_q;
      else                           cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      rise_q  <= level_q & ~prev_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/wam_round_ctrl.sv
// Round controller for the whack-a-mole core: debounced start/difficulty buttons, launch pulse,
// countdown, freeze and score latch at time-up. WAM_HISCORE_EN adds the best-score register.
module wam_round_ctrl
  import wam_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int ROUND_SEC = 30,
  parameter int DEB_CYC   = 500_000,
  parameter int START_CYC = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             btn_start,
  input  logic             btn_diff,
  input  logic [BCD_W-1:0] score_in,
  output logic             game_start,
  output logic             game_pause,
  output logic [1:0]       difficulty,
  output logic [6:0]       time_left,
  output logic             game_over,
  output logic [BCD_W-1:0] final_score,
  output logic [BCD_W-1:0] best_score
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int LW = $clog2(START_CYC + 1);

  logic start_p, diff_p, start_lvl, diff_lvl;
  logic unused_lvl;

  state_e           state_q, state_d;
  logic [LW-1:0]    launch_cnt_q, launch_cnt_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [6:0]       time_left_q, time_left_d;
  logic [1:0]       diff_q, diff_d;
  logic [BCD_W-1:0] final_q, final_d;
  logic             start_q, pause_q, over_q;

  wam_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
    .clk     (clk),
    .clr     (clr),
    .raw_i   (btn_start),
    .level_o (start_lvl),
    .rise_o  (start_p)
  );

  wam_debounce #(.DEB_CYC(DEB_CYC)) u_deb_diff (
    .clk     (clk),
    .clr     (clr),
    .raw_i   (btn_diff),
    .level_o (diff_lvl),
    .rise_o  (diff_p)
  );

  assign unused_lvl = start_lvl ^ diff_lvl;

  always_comb begin
    state_d      = state_q;
    launch_cnt_d = launch_cnt_q;
    tick_d       = tick_q;
    time_left_d  = time_left_q;
    diff_d       = diff_q;
    final_d      = final_q;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (diff_p)  diff_d  = diff_next(diff_q);
        if (start_p) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (launch_cnt_q == LW'(START_CYC - 1)) state_d = ST_PLAY;
        else                                    launch_cnt_d = launch_cnt_q + 1'b1;
      end
      ST_PLAY: begin
        if (start_p) begin
          state_d = ST_LAUNCH;
        end else if (tick_q == TW'(TICK_DIV - 1)) begin
          tick_d      = '0;
          time_left_d = time_left_q - 7'd1;
          if (time_left_q == 7'd1) begin
            final_d = score_in;
            state_d = ST_OVER;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
    endcase

    // Everything a round needs is reset on the entry edge so LAUNCH shows a full clock at once.
    if (state_d == ST_LAUNCH && state_q != ST_LAUNCH) begin
      launch_cnt_d = '0;
      tick_d       = '0;
      time_left_d  = 7'(ROUND_SEC);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      launch_cnt_q <= '0;
      tick_q       <= '0;
      time_left_q  <= 7'(ROUND_SEC);
      diff_q       <= DIFF_EASY;
      final_q      <= '0;
      start_q      <= 1'b0;
      pause_q      <= 1'b1;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      launch_cnt_q <= launch_cnt_d;
      tick_q       <= tick_d;
      time_left_q  <= time_left_d;
      diff_q       <= diff_d;
      final_q      <= final_d;
      start_q      <= (state_d == ST_LAUNCH);
      pause_q      <= (state_d != ST_PLAY);
      over_q       <= (state_d == ST_OVER);
    end
  end

`ifdef WAM_HISCORE_EN
  logic [BCD_W-1:0] best_q;
  logic             over_ent_q;

  // BCD digits order the same way as binary, so a plain unsigned compare ranks scores.
  always_ff @(posedge clk) begin
    if (clr) begin
      best_q     <= '0;
      over_ent_q <= 1'b0;
    end else begin
      over_ent_q <= (state_d == ST_OVER) && (state_q != ST_OVER);
      if (over_ent_q && (final_q > best_q)) best_q <= final_q;
    end
  end

  assign best_score = best_q;
`else
  assign best_score = '0;
`endif

  assign game_start  = start_q;
  assign game_pause  = pause_q;
  assign game_over   = over_q;
  assign difficulty  = diff_q;
  assign time_left   = time_left_q;
  assign final_score = final_q;

endmodule

// File: tb/tb_wam_round_ctrl.sv
// Scoreboard bench for wam_round_ctrl: expected output snapshots are queued by the stimulus and
// checked by a monitor whenever the output bundle changes or a steady-state probe is requested.
module tb_wam_round_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int ROUND_SEC = 3;
  localparam int DEB_CYC   = 4;
  localparam int START_CYC = 4;

`ifdef WAM_HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, btn_start, btn_diff;
  logic [11:0] score_in;
  logic        game_start, game_pause, game_over;
  logic [1:0]  difficulty;
  logic [6:0]  time_left;
  logic [11:0] final_score, best_score;

  always #5 clk = ~clk;

  wam_round_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .ROUND_SEC (ROUND_SEC),
    .DEB_CYC   (DEB_CYC),
    .START_CYC (START_CYC)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .btn_start   (btn_start),
    .btn_diff    (btn_diff),
    .score_in    (score_in),
    .game_start  (game_start),
    .game_pause  (game_pause),
    .difficulty  (difficulty),
    .time_left   (time_left),
    .game_over   (game_over),
    .final_score (final_score),
    .best_score  (best_score)
  );

  typedef struct packed {
    logic        gs;
    logic        gp;
    logic [1:0]  df;
    logic [6:0]  tl;
    logic        go;
    logic [11:0] fs;
    logic [11:0] bs;
  } snap_t;

  snap_t exp_q[$];
  int    gap_q[$];
  string nm_q[$];

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  bit    mon_en = 1'b0;
  bit    started = 1'b0;
  bit    probe = 1'b0;
  snap_t prev, cur;

  function automatic snap_t mk(input logic gs, input logic gp, input logic [1:0] df,
                               input logic [6:0] tl, input logic go,
                               input logic [11:0] fs, input logic [11:0] bs);
    snap_t s;
    s.gs = gs; s.gp = gp; s.df = df; s.tl = tl; s.go = go; s.fs = fs; s.bs = bs;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("gs=%0b gp=%0b diff=%0d tl=%0d go=%0b fs=%03h bs=%03h",
                     s.gs, s.gp, s.df, s.tl, s.go, s.fs, s.bs);
  endfunction

  function automatic logic [11:0] bsel(input logic [11:0] v);
    return HS ? v : 12'h000;
  endfunction

  task automatic push(input snap_t s, input int gap, input string nm);
    exp_q.push_back(s);
    gap_q.push_back(gap);
    nm_q.push_back(nm);
  endtask

  // Monitor: an output event is any change of the bundle, or a probe pulse from the stimulus.
  always @(negedge clk) begin
    snap_t e;
    int    g;
    string nm;
    bit    changed;
    cyc = cyc + 1;
    if (mon_en) begin
      cur = {game_start, game_pause, difficulty, time_left, game_over, final_score, best_score};
      if (!started) begin
        prev    = cur;
        started = 1'b1;
      end else begin
        changed = (cur !== prev);
        if (changed || probe) begin
          n_cmp = n_cmp + 1;
          if (exp_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL unexpected_event: got %s at cycle %0d", fmt(cur), cyc);
          end else begin
            e  = exp_q.pop_front();
            g  = gap_q.pop_front();
            nm = nm_q.pop_front();
            if (cur !== e || (g >= 0 && (cyc - last_cyc) != g)) begin
              n_bad = n_bad + 1;
              $display("FAIL %s: got %s gap %0d, want %s gap %0d",
                       nm, fmt(cur), cyc - last_cyc, fmt(e), g);
            end
          end
          if (changed) last_cyc = cyc;
          prev = cur;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit s, input bit d, input int hi);
    btn_start = s;
    btn_diff  = d;
    tick(hi);
    btn_start = 1'b0;
    btn_diff  = 1'b0;
  endtask

  task automatic wait_tl(input logic [6:0] v, input int budget, input string nm);
    int k = 0;
    while (time_left !== v && k < budget) begin
      tick(1);
      k++;
    end
    if (time_left !== v) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: timeout, time_left=%0d want %0d", nm, time_left, v);
    end
  endtask

  task automatic wait_pause(input logic v, input int budget, input string nm);
    int k = 0;
    while (game_pause !== v && k < budget) begin
      tick(1);
      k++;
    end
    if (game_pause !== v) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: timeout, game_pause=%0b want %0b", nm, game_pause, v);
    end
  endtask

  task automatic wait_over(input int budget, input string nm);
    int k = 0;
    while (game_over !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    if (game_over !== 1'b1) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: timeout, game_over=%0b want 1", nm, game_over);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    snap_t rst;
    rst = mk(1'b0, 1'b1, 2'd0, 7'd3, 1'b0, 12'h000, 12'h000);

    clr = 1'b1; btn_start = 1'b0; btn_diff = 1'b0; score_in = 12'h057;
    tick(3);
    mon_en = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(20);
    push(rst, -1, "reset_idle");
    probe = 1'b1; tick(1); probe = 1'b0;

    // Difficulty cycles 1,2,0,1 in IDLE.
    for (int k = 1; k <= 4; k++) begin
      push(mk(1'b0, 1'b1, 2'(k % 3), 7'd3, 1'b0, 12'h000, 12'h000), -1, "idle_diff");
      press(1'b0, 1'b1, 8);
      tick(12);
    end

    // Round 1: bouncy start, diff press ignored during PLAY, ends at 057.
    push(mk(1'b1, 1'b1, 2'd1, 7'd3, 1'b0, 12'h000, 12'h000), -1, "r1_launch");
    push(mk(1'b0, 1'b0, 2'd1, 7'd3, 1'b0, 12'h000, 12'h000), START_CYC, "r1_play");
    push(mk(1'b0, 1'b0, 2'd1, 7'd2, 1'b0, 12'h000, 12'h000), TICK_DIV, "r1_tl2");
    push(mk(1'b0, 1'b0, 2'd1, 7'd1, 1'b0, 12'h000, 12'h000), TICK_DIV, "r1_tl1");
    push(mk(1'b0, 1'b1, 2'd1, 7'd0, 1'b1, 12'h057, 12'h000), TICK_DIV, "r1_over");
    if (HS) push(mk(1'b0, 1'b1, 2'd1, 7'd0, 1'b1, 12'h057, 12'h057), 1, "r1_best");
    btn_start = 1'b1; tick(2);
    btn_start = 1'b0; tick(2);
    btn_start = 1'b1; tick(12);
    btn_start = 1'b0;
    wait_pause(1'b0, 40, "r1_wait_play");
    press(1'b0, 1'b1, 8);
    tick(12);
    wait_over(100, "r1_wait_over");
    tick(5);

    // Round 2: restart at time_left 2, then run out at 042 (no new best).
    score_in = 12'h042;
    push(mk(1'b1, 1'b1, 2'd1, 7'd3, 1'b0, 12'h057, bsel(12'h057)), -1, "r2_launch");
    push(mk(1'b0, 1'b0, 2'd1, 7'd3, 1'b0, 12'h057, bsel(12'h057)), START_CYC, "r2_play");
    push(mk(1'b0, 1'b0, 2'd1, 7'd2, 1'b0, 12'h057, bsel(12'h057)), TICK_DIV, "r2_tl2");
    press(1'b1, 1'b0, 8);
    wait_tl(7'd2, 60, "r2_wait_tl2");
    push(mk(1'b1, 1'b1, 2'd1, 7'd3, 1'b0, 12'h057, bsel(12'h057)), -1, "r2_relaunch");
    push(mk(1'b0, 1'b0, 2'd1, 7'd3, 1'b0, 12'h057, bsel(12'h057)), START_CYC, "r2_replay");
    push(mk(1'b0, 1'b0, 2'd1, 7'd2, 1'b0, 12'h057, bsel(12'h057)), TICK_DIV, "r2_tl2b");
    push(mk(1'b0, 1'b0, 2'd1, 7'd1, 1'b0, 12'h057, bsel(12'h057)), TICK_DIV, "r2_tl1");
    push(mk(1'b0, 1'b1, 2'd1, 7'd0, 1'b1, 12'h042, bsel(12'h057)), TICK_DIV, "r2_over");
    press(1'b1, 1'b0, 8);
    wait_over(100, "r2_wait_over");
    tick(5);

    // Round 3: start and diff together from OVER, ends at 103 (new best).
    score_in = 12'h103;
    push(mk(1'b1, 1'b1, 2'd2, 7'd3, 1'b0, 12'h042, bsel(12'h057)), -1, "r3_launch");
    push(mk(1'b0, 1'b0, 2'd2, 7'd3, 1'b0, 12'h042, bsel(12'h057)), START_CYC, "r3_play");
    push(mk(1'b0, 1'b0, 2'd2, 7'd2, 1'b0, 12'h042, bsel(12'h057)), TICK_DIV, "r3_tl2");
    push(mk(1'b0, 1'b0, 2'd2, 7'd1, 1'b0, 12'h042, bsel(12'h057)), TICK_DIV, "r3_tl1");
    push(mk(1'b0, 1'b1, 2'd2, 7'd0, 1'b1, 12'h103, bsel(12'h057)), TICK_DIV, "r3_over");
    if (HS) push(mk(1'b0, 1'b1, 2'd2, 7'd0, 1'b1, 12'h103, 12'h103), 1, "r3_best");
    press(1'b1, 1'b1, 8);
    tick(12);
    wait_over(100, "r3_wait_over");
    tick(5);

    // clr from OVER returns everything, including best_score, to reset values.
    push(rst, -1, "clr_event");
    clr = 1'b1; tick(2); clr = 1'b0;
    tick(5);
    push(rst, -1, "post_clr");
    probe = 1'b1; tick(1); probe = 1'b0;

    tick(5);
    if (exp_q.size() != 0) begin
      $display("FAIL leftover: %0d expected events never seen, first %s", exp_q.size(), nm_q[0]);
      n_cmp = n_cmp + exp_q.size();
      n_bad = n_bad + exp_q.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
